// File: rtl/w5500_pkg.sv
// Shared definitions for the W5500 bring-up driver: register map, block-select codes,
// command values, sequencer state and SPI frame helpers.
package w5500_pkg;

  // Common register block
  localparam logic [15:0] ADDR_SHAR    = 16'h0009;
  localparam logic [15:0] ADDR_GAR     = 16'h0001;
  localparam logic [15:0] ADDR_SUBR    = 16'h0005;
  localparam logic [15:0] ADDR_SIPR    = 16'h000F;
  // Socket register block
  localparam logic [15:0] ADDR_SN_MR   = 16'h0000;
  localparam logic [15:0] ADDR_SN_CR   = 16'h0001;
  localparam logic [15:0] ADDR_SN_IR   = 16'h0002;
  localparam logic [15:0] ADDR_SN_PORT = 16'h0004;

  localparam logic [4:0] BSB_COMMON = 5'b00000;
  localparam logic [4:0] BSB_S0_REG = 5'b00001;

  localparam logic RWB_READ  = 1'b0;
  localparam logic RWB_WRITE = 1'b1;

  localparam logic [7:0] SN_MR_TCP    = 8'h01;
  localparam logic [7:0] SN_CR_OPEN   = 8'h01;
  localparam logic [7:0] SN_CR_LISTEN = 8'h02;

  typedef enum logic [2:0] {
    StHwRst,
    StBoot,
    StCfg,
    StIdle,
    StSvcRd,
    StSvcClr
  } state_e;

  // One SPI frame: address phase, control phase, len data bytes. Data is left-aligned so
  // the first byte on the wire is data[47:40].
  typedef struct packed {
    logic [15:0] addr;
    logic [4:0]  bsb;
    logic        rwb;
    logic [3:0]  len;
    logic [47:0] data;
  } frame_t;

  // Control byte in variable-data-length mode (OM = 00).
  function automatic logic [7:0] ctrl_byte(input logic [4:0] bsb, input logic rwb);
    return {bsb, rwb, 2'b00};
  endfunction

  function automatic frame_t mk_frame(input logic [15:0] addr, input logic [4:0] bsb,
                                      input logic rwb, input logic [3:0] len,
                                      input logic [47:0] data);
    frame_t f;
    f.addr = addr;
    f.bsb  = bsb;
    f.rwb  = rwb;
    f.len  = len;
    f.data = data;
    return f;
  endfunction

  // Byte idx of the frame as it appears on MOSI.
  function automatic logic [7:0] frame_byte(input frame_t f, input logic [3:0] idx);
    logic [7:0]  b;
    logic [47:0] sh;
    sh = f.data << {idx - 4'd3, 3'b000};
    case (idx)
      4'd0:    b = f.addr[15:8];
      4'd1:    b = f.addr[7:0];
      4'd2:    b = ctrl_byte(f.bsb, f.rwb);
      default: b = sh[47:40];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/w5500_spi_byte.sv
// Mode-0 SPI byte engine: one byte per start strobe, MSB first, SCLK half-period of
// SPI_DIV clocks. MOSI moves on the falling edge, MISO is taken at the rising edge.
module w5500_spi_byte #(
  parameter int unsigned SPI_DIV = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic [7:0] rx_byte_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o
);

  logic        active_q, active_d;
  logic        sclk_q, sclk_d;
  logic [31:0] div_q, div_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        done_q, done_d;

  // Divider, shift and sample next-state
  always_comb begin
    active_d = active_q;
    sclk_d   = sclk_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    done_d   = 1'b0;
    if (!active_q) begin
      if (start_i) begin
        active_d = 1'b1;
        sclk_d   = 1'b0;
        div_d    = '0;
        bit_d    = '0;
        tx_d     = tx_byte_i;
      end
    end else if (div_q == SPI_DIV - 1) begin
      div_d = '0;
      if (!sclk_q) begin
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], miso_i};
      end else begin
        sclk_d = 1'b0;
        if (bit_q == 3'd7) begin
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          tx_d  = {tx_q[6:0], 1'b0};
        end
      end
    end else begin
      div_d = div_q + 32'd1;
    end
  end

  // Engine state register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      done_q   <= done_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign mosi_o    = active_q & tx_q[7];
  assign rx_byte_o = rx_q;
  assign done_o    = done_q;

endmodule

// File: rtl/w5500_driver.sv
// W5500 bring-up and interrupt service sequencer. Resets the chip, writes network and
// socket 0 configuration, opens a TCP listener, then services Sn_IR on each interrupt.
// Build option W5500_SHAR_CFG_EN: also writes MAC_ADDR to SHAR as the first frame.
module w5500_driver
  import w5500_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter logic [31:0] IP_ADDR      = 32'hC0A80001,
  parameter logic [31:0] GATEWAY_ADDR = 32'hC0A80001,
  parameter logic [31:0] SUBNET_MASK  = 32'hFFFFFF00,
  parameter logic [15:0] PORT         = 16'h1337,
  parameter int unsigned SPI_DIV      = 2,
  parameter int unsigned RST_CYCLES   = 16,
`ifdef W5500_SHAR_CFG_EN
  parameter logic [47:0] MAC_ADDR     = 48'h00_08_DC_01_02_03,
`endif
  parameter int unsigned BOOT_CYCLES  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_miso,
  output logic                  o_spi_mosi,
  output logic                  o_spi_clk,
  output logic                  o_spi_cs,
  output logic                  o_w5500_rst,
  input  logic                  i_w5500_int,
  output logic                  o_busy,
  output logic                  o_data_ready,
  output logic [DATA_WIDTH-1:0] o_data_out
);

`ifdef W5500_SHAR_CFG_EN
  localparam int unsigned NumCfg = 8;
`else
  localparam int unsigned NumCfg = 7;
`endif
  localparam logic [3:0]  LastCfg   = 4'(NumCfg - 1);
  localparam int unsigned GapCycles = 2 * SPI_DIV;

  // Configuration frame ROM, in wire order.
  function automatic frame_t cfg_frame(input logic [3:0] idx);
    frame_t     f;
    logic [3:0] k;
`ifdef W5500_SHAR_CFG_EN
    k = idx - 4'd1;  // SHAR sits at idx 0, which wraps to 4'hF
`else
    k = idx;
`endif
    case (k)
      4'd0:    f = mk_frame(ADDR_GAR, BSB_COMMON, RWB_WRITE, 4'd4, {GATEWAY_ADDR, 16'h0});
      4'd1:    f = mk_frame(ADDR_SUBR, BSB_COMMON, RWB_WRITE, 4'd4, {SUBNET_MASK, 16'h0});
      4'd2:    f = mk_frame(ADDR_SIPR, BSB_COMMON, RWB_WRITE, 4'd4, {IP_ADDR, 16'h0});
      4'd3:    f = mk_frame(ADDR_SN_MR, BSB_S0_REG, RWB_WRITE, 4'd1, {SN_MR_TCP, 40'h0});
      4'd4:    f = mk_frame(ADDR_SN_PORT, BSB_S0_REG, RWB_WRITE, 4'd2, {PORT, 32'h0});
      4'd5:    f = mk_frame(ADDR_SN_CR, BSB_S0_REG, RWB_WRITE, 4'd1, {SN_CR_OPEN, 40'h0});
      4'd6:    f = mk_frame(ADDR_SN_CR, BSB_S0_REG, RWB_WRITE, 4'd1, {SN_CR_LISTEN, 40'h0});
`ifdef W5500_SHAR_CFG_EN
      4'hF:    f = mk_frame(ADDR_SHAR, BSB_COMMON, RWB_WRITE, 4'd6, MAC_ADDR);
`endif
      default: f = mk_frame(ADDR_GAR, BSB_COMMON, RWB_WRITE, 4'd4, {GATEWAY_ADDR, 16'h0});
    endcase
    return f;
  endfunction

  state_e                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [3:0]            frame_idx_q, frame_idx_d;
  logic [3:0]            byte_idx_q, byte_idx_d;
  logic                  cs_q, cs_d;
  logic                  wrst_q, wrst_d;
  logic                  busy_q, busy_d;
  logic                  rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [7:0]            svc_q, svc_d;
  logic                  pend_q, pend_d;
  logic [2:0]            int_sync_q;
  logic                  int_rise;

  frame_t     cur_frame;
  logic [3:0] tx_idx;
  logic       spi_start;
  logic [7:0] spi_tx;
  logic [7:0] spi_rx;
  logic       spi_done;

  assign int_rise = int_sync_q[1] & ~int_sync_q[2];
  assign spi_tx   = frame_byte(cur_frame, tx_idx);

  w5500_spi_byte #(
    .SPI_DIV (SPI_DIV)
  ) u_spi_byte (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .start_i   (spi_start),
    .tx_byte_i (spi_tx),
    .miso_i    (i_spi_miso),
    .rx_byte_o (spi_rx),
    .done_o    (spi_done),
    .sclk_o    (o_spi_clk),
    .mosi_o    (o_spi_mosi)
  );

  // Select the frame the current state is shifting out
  always_comb begin
    unique case (state_q)
      StSvcRd:  cur_frame = mk_frame(ADDR_SN_IR, BSB_S0_REG, RWB_READ, 4'd1, 48'h0);
      StSvcClr: cur_frame = mk_frame(ADDR_SN_IR, BSB_S0_REG, RWB_WRITE, 4'd1, {svc_q, 40'h0});
      default:  cur_frame = cfg_frame(frame_idx_q);
    endcase
  end

  // Sequencer next-state, cs framing and byte issue
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_idx_d = frame_idx_q;
    byte_idx_d  = byte_idx_q;
    cs_d        = cs_q;
    wrst_d      = wrst_q;
    rdy_d       = 1'b0;
    dout_d      = dout_q;
    svc_d       = svc_q;
    pend_d      = pend_q;
    spi_start   = 1'b0;
    tx_idx      = byte_idx_q;
    unique case (state_q)
      StHwRst: begin
        wrst_d = 1'b0;
        if (cnt_q == RST_CYCLES - 1) begin
          cnt_d   = '0;
          wrst_d  = 1'b1;
          state_d = StBoot;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StBoot: begin
        if (cnt_q == BOOT_CYCLES - 1) begin
          cnt_d       = '0;
          frame_idx_d = '0;
          state_d     = StCfg;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StIdle: begin
        if (pend_q) begin
          // Clear on entry so an edge arriving during the service re-arms it.
          pend_d  = 1'b0;
          cnt_d   = '0;
          state_d = StSvcRd;
        end
      end
      StCfg, StSvcRd, StSvcClr: begin
        if (cs_q) begin
          // Inter-frame gap, then drop cs and launch the address MSB together.
          if (cnt_q >= GapCycles - 1) begin
            cs_d       = 1'b0;
            cnt_d      = '0;
            byte_idx_d = '0;
            tx_idx     = '0;
            spi_start  = 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else if (spi_done) begin
          if (state_q == StSvcRd && byte_idx_q == 4'd3) begin
            svc_d  = spi_rx;
            dout_d = DATA_WIDTH'(spi_rx);
            rdy_d  = 1'b1;
          end
          if (byte_idx_q == cur_frame.len + 4'd2) begin
            cs_d  = 1'b1;
            cnt_d = '0;
            if (state_q == StCfg) begin
              if (frame_idx_q == LastCfg) begin
                state_d = StIdle;
              end else begin
                frame_idx_d = frame_idx_q + 4'd1;
              end
            end else if (state_q == StSvcRd) begin
              state_d = StSvcClr;
            end else begin
              state_d = StIdle;
            end
          end else begin
            byte_idx_d = byte_idx_q + 4'd1;
            tx_idx     = byte_idx_q + 4'd1;
            spi_start  = 1'b1;
          end
        end
      end
      default: state_d = StHwRst;
    endcase
    if (int_rise) begin
      pend_d = 1'b1;
    end
    busy_d = (state_d != StIdle);
  end

  // Sequencer registers and interrupt synchronizer, synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StHwRst;
      cnt_q       <= '0;
      frame_idx_q <= '0;
      byte_idx_q  <= '0;
      cs_q        <= 1'b1;
      wrst_q      <= 1'b0;
      busy_q      <= 1'b1;
      rdy_q       <= 1'b0;
      dout_q      <= '0;
      svc_q       <= '0;
      pend_q      <= 1'b0;
      int_sync_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_idx_q <= frame_idx_d;
      byte_idx_q  <= byte_idx_d;
      cs_q        <= cs_d;
      wrst_q      <= wrst_d;
      busy_q      <= busy_d;
      rdy_q       <= rdy_d;
      dout_q      <= dout_d;
      svc_q       <= svc_d;
      pend_q      <= pend_d;
      int_sync_q  <= {int_sync_q[1:0], i_w5500_int};
    end
  end

  assign o_spi_cs     = cs_q;
  assign o_w5500_rst  = wrst_q;
  assign o_busy       = busy_q;
  assign o_data_ready = rdy_q;
  assign o_data_out   = dout_q;

endmodule

// File: tb/tb_w5500_driver.sv
// Bench for w5500_driver: SPI slave model records frames, a scoreboard of expected frames
// and status bytes is checked by monitors as frames close and data_ready strobes.
module tb_w5500_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       int_i = 1'b0;
  logic       miso;
  logic       mosi, sclk, cs, wrst, busy, rdy;
  logic [7:0] dout;

  always #5 clk = ~clk;

  w5500_driver #(
    .SPI_DIV     (2),
    .RST_CYCLES  (4),
    .BOOT_CYCLES (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_spi_miso   (miso),
    .o_spi_mosi   (mosi),
    .o_spi_clk    (sclk),
    .o_spi_cs     (cs),
    .o_w5500_rst  (wrst),
    .i_w5500_int  (int_i),
    .o_busy       (busy),
    .o_data_ready (rdy),
    .o_data_out   (dout)
  );

  typedef struct packed {
    logic [3:0]  n;
    logic [71:0] b;
    logic [71:0] m;
  } frm_t;

  frm_t       exp_q[$];
  logic [7:0] exp_d[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] sir_val = 8'h00;
  bit         abort = 1'b0;
  localparam int Limit = 20000;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Expected frame; bytes given right-aligned, dc masks the final byte.
  task automatic push_frame(input int n, input logic [71:0] bytes, input bit dc);
    frm_t f;
    int   sh;
    sh  = 8 * (9 - n);
    f.n = 4'(n);
    f.b = bytes << sh;
    f.m = {72{1'b1}} << sh;
    if (dc) f.m = f.m & ~(72'hFF << sh);
    exp_q.push_back(f);
  endtask

  task automatic push_cfg();
`ifdef W5500_SHAR_CFG_EN
    push_frame(9, 72'h0009_04_0008DC010203, 1'b0);
`endif
    push_frame(7, 72'h0001_04_C0A80001, 1'b0);
    push_frame(7, 72'h0005_04_FFFFFF00, 1'b0);
    push_frame(7, 72'h000F_04_C0A80001, 1'b0);
    push_frame(4, 72'h0000_0C_01, 1'b0);
    push_frame(5, 72'h0004_0C_1337, 1'b0);
    push_frame(4, 72'h0001_0C_01, 1'b0);
    push_frame(4, 72'h0001_0C_02, 1'b0);
  endtask

  // One interrupt service: Sn_IR read, status byte out, same byte written back.
  task automatic push_svc(input logic [7:0] v);
    push_frame(4, {48'h0, 24'h0002_08, 8'h00}, 1'b1);
    push_frame(4, {48'h0, 24'h0002_0C, v}, 1'b0);
    exp_d.push_back(v);
  endtask

  task automatic pulse(input int w);
    int_i = 1'b1;
    repeat (w) @(negedge clk);
    int_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || exp_d.size() != 0 || busy) && t < Limit) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_timeout"}, 72'(t >= Limit), 72'(0));
  endtask

  // SPI slave: samples on the falling system clock, decodes SCLK/CS edges.
  logic        pcs = 1'b1, psclk = 1'b0;
  int          bitcnt = 0, nbytes = 0;
  logic [7:0]  rx_sh = '0, tx_sh = '0, ctrl = '0;
  logic [71:0] cur = '0;
  assign miso = tx_sh[7];

  always @(negedge clk) begin
    if (pcs && !cs) begin
      bitcnt = 0;
      nbytes = 0;
      cur    = '0;
      tx_sh  = 8'($urandom);
    end else if (!pcs && cs) begin
      if (abort) begin
        abort = 1'b0;
      end else begin
        chk("frame_expected", 72'(exp_q.size() != 0), 72'(1));
        if (exp_q.size() != 0) begin
          frm_t        e;
          logic [71:0] got;
          e   = exp_q.pop_front();
          got = (nbytes <= 9) ? (cur << (8 * (9 - nbytes))) : cur;
          chk("frame_len", 72'(nbytes), 72'(e.n));
          chk("frame_bytes", got & e.m, e.b & e.m);
        end
      end
    end else if (!cs) begin
      if (!psclk && sclk) begin
        rx_sh = {rx_sh[6:0], mosi};
        bitcnt++;
      end else if (psclk && !sclk) begin
        if (bitcnt == 8) begin
          cur = {cur[63:0], rx_sh};
          nbytes++;
          if (nbytes == 3) ctrl = rx_sh;
          bitcnt = 0;
          tx_sh  = (nbytes >= 3 && !ctrl[2]) ? sir_val : 8'($urandom);
        end else begin
          tx_sh = {tx_sh[6:0], 1'b0};
        end
      end
    end
    pcs   = cs;
    psclk = sclk;
  end

  // Status byte monitor
  always @(negedge clk) begin
    if (rdy) begin
      chk("ready_expected", 72'(exp_d.size() != 0), 72'(1));
      if (exp_d.size() != 0) chk("data_out", 72'(dout), 72'(exp_d.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int         n;
    int         t;
    bit         busy_ok;
    logic [7:0] v;

    repeat (3) @(negedge clk);
    chk("rst_cs", 72'(cs), 72'(1));
    chk("rst_sclk", 72'(sclk), 72'(0));
    chk("rst_mosi", 72'(mosi), 72'(0));
    chk("rst_w5500_rst", 72'(wrst), 72'(0));
    chk("rst_busy", 72'(busy), 72'(1));
    chk("rst_ready", 72'(rdy), 72'(0));
    chk("rst_data", 72'(dout), 72'(0));
    push_cfg();
    rst = 1'b0;

    n = 0;
    while (!wrst && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("w5500_rst_low_cycles", 72'(n), 72'(4));

    n = 0;
    busy_ok = 1'b1;
    while (cs && n < 1000) begin
      if (!busy) busy_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("cs_high_through_boot", 72'(n >= 4 && n < 1000), 72'(1));
    chk("busy_through_boot", 72'(busy_ok), 72'(1));

    // Two edges during CFG coalesce into one service after CFG.
    n = 0;
    t = 0;
    while (n < 2 && t < Limit) begin
      @(posedge cs or negedge clk);
      if (cs && pcs == 1'b0) n++;
      t++;
    end
    sir_val = 8'h5A;
    push_svc(8'h5A);
    pulse(3);
    repeat (10) @(negedge clk);
    pulse(2);
    wait_idle("cfg_and_svc");
    chk("idle_cs", 72'(cs), 72'(1));

    // Basic service: Sn_IR = 0x01, 5-cycle pulse.
    sir_val = 8'h01;
    push_svc(8'h01);
    pulse(5);
    t = 0;
    while (!busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("busy_rise", 72'(t < 100), 72'(1));
    wait_idle("svc_basic");

    // Randomized services.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge clk);
      v = 8'($urandom_range(1, 255));
      sir_val = v;
      push_svc(v);
      pulse($urandom_range(1, 8));
      wait_idle("svc_rand");
    end

    // Edge during the service re-arms a second one.
    sir_val = 8'hA5;
    push_svc(8'hA5);
    pulse(4);
    t = 0;
    while (!rdy && t < Limit) begin
      @(negedge clk);
      t++;
    end
    chk("rearm_first_ready", 72'(t < Limit), 72'(1));
    sir_val = 8'h3C;
    push_svc(8'h3C);
    pulse(3);
    wait_idle("svc_rearm");

    // Reset in the middle of a frame; whole bring-up replays.
    sir_val = 8'($urandom);
    pulse(3);
    t = 0;
    while (cs && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("abort_frame_started", 72'(t < 1000), 72'(1));
    repeat (40) @(negedge clk);
    abort = 1'b1;
    exp_q.delete();
    exp_d.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cs", 72'(cs), 72'(1));
    chk("midrst_sclk", 72'(sclk), 72'(0));
    chk("midrst_w5500_rst", 72'(wrst), 72'(0));
    chk("midrst_busy", 72'(busy), 72'(1));
    rst = 1'b0;
    push_cfg();
    wait_idle("replay");

    chk("frames_left", 72'(exp_q.size()), 72'(0));
    chk("data_left", 72'(exp_d.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
